mem_access_unit: RTL and testbench

- Processor-side initiator for the data memory. Accepts one load/store request at a time and drives the memory port (addr/wdata/size/we/re).
- Memory reads are combinational and writes commit on posedge.
- Splits loads that cross a word boundary into two aligned word reads, then merges, aligns and sign/zero-extends the result.
- Rejects misaligned stores and out-of-window addresses with an error response; the memory is never touched in those cases.

---
 rtl/mem_access_unit_pkg.sv | 37 +++
 rtl/mem_access_unit_if.sv | 50 +++++
 rtl/mem_access_unit_load_align_extend.sv | 32 +++
 rtl/mem_access_unit.sv | 155 +++++++++++++++
 tb/tb_mem_access_unit.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_unit_pkg.sv
// ============================================================================
// Module   : mem_access_pkg
// Purpose  : Shared size codes, FSM state encodings and helpers for mem_access_unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_access_pkg;

    typedef logic [1:0] size_t;

    localparam size_t SIZE_BYTE = 2'd0;
    localparam size_t SIZE_HALF = 2'd1;
    localparam size_t SIZE_RSVD = 2'd2;
    localparam size_t SIZE_WORD = 2'd3;

    typedef logic [2:0] state_t;

    localparam state_t IDLE = 3'd0;
    localparam state_t RD0  = 3'd1;
    localparam state_t RD1  = 3'd2;
    localparam state_t WR   = 3'd3;
    localparam state_t RESP = 3'd4;

    // The reserved code reports zero bytes; it is rejected before it matters.
    function automatic logic [2:0] bytes_of(input size_t size);
        case (size)
            SIZE_BYTE: bytes_of = 3'd1;
            SIZE_HALF: bytes_of = 3'd2;
            SIZE_WORD: bytes_of = 3'd4;
            default:   bytes_of = 3'd0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_unit_if.sv
// ============================================================================
// Module   : mem_req_if / mem_port_if
// Purpose  : Requester-side handshake bundle and data-memory port bundle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_req_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_data, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output req_ready, resp_valid, resp_data, resp_err
    );
endinterface

interface mem_port_if;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_size;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_rdata;

    modport master (
        output mem_addr, mem_wdata, mem_size, mem_we, mem_re,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_size, mem_we, mem_re,
        output mem_rdata
    );
endinterface

`default_nettype wire

// File: rtl/mem_access_unit_load_align_extend.sv
// ============================================================================
// Module   : load_align_extend
// Purpose  : Merges two aligned words, shifts the addressed lanes down and extends.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_align_extend
    import mem_access_pkg::*;
(
    input  logic [31:0] buf0,
    input  logic [31:0] buf1,
    input  logic [1:0]  offset,
    input  size_t       size,
    input  logic        is_signed,
    output logic [31:0] result
);

    logic [31:0] w_raw;

    always_comb begin
        w_raw = 32'({buf1, buf0} >> {offset, 3'b000});
        case (size)
            SIZE_BYTE: result = {{24{is_signed & w_raw[7]}},  w_raw[7:0]};
            SIZE_HALF: result = {{16{is_signed & w_raw[15]}}, w_raw[15:0]};
            default:   result = w_raw;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
// Module   : mem_access_unit
// Purpose  : Single-outstanding load/store initiator with split crossing loads.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter logic [15:0] MEM_ADDR = 16'h1000
)
(
    input  logic          clock,
    input  logic          reset,
    mem_req_if.slave      req,
    mem_port_if.master    mem
);

    state_t      r_state;
    size_t       r_size;
    logic        r_signed;
    logic [31:0] r_addr;
    logic [31:0] r_buf0;
    logic [31:0] r_buf1;

    logic [2:0]  w_bytes;
    logic        w_crossing;
    logic        w_err;
    logic        r_crossing;
    logic [31:0] w_buf0;
    logic [31:0] w_buf1;
    logic [31:0] w_load_result;

    assign req.req_ready = (r_state == IDLE);

    // Accept-time decode; the second-word window test reduces to the word
    // index being the last one of the 64 KiB window.
    always_comb begin
        w_bytes    = bytes_of(req.req_size);
        w_crossing = ({1'b0, req.req_addr[1:0]} + w_bytes) > 3'd4;
        w_err      = 1'b0;
        if (req.req_size == SIZE_RSVD)
            w_err = 1'b1;
        else if (req.req_addr[31:16] != MEM_ADDR)
            w_err = 1'b1;
        else if (req.req_we && (((req.req_size == SIZE_HALF) && req.req_addr[0]) ||
                                ((req.req_size == SIZE_WORD) && (req.req_addr[1:0] != 2'b00))))
            w_err = 1'b1;
        else if (!req.req_we && w_crossing && (&req.req_addr[15:2]))
            w_err = 1'b1;
    end

    assign r_crossing = ({1'b0, r_addr[1:0]} + bytes_of(r_size)) > 3'd4;

    // Feed the word being read this cycle straight into the merge so the
    // response registers in the same edge that captures the last word.
    assign w_buf0 = (r_state == RD0) ? mem.mem_rdata : r_buf0;
    assign w_buf1 = (r_state == RD1) ? mem.mem_rdata : r_buf1;

    load_align_extend u_align (
        .buf0      (w_buf0),
        .buf1      (w_buf1),
        .offset    (r_addr[1:0]),
        .size      (r_size),
        .is_signed (r_signed),
        .result    (w_load_result)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= IDLE;
            r_size         <= SIZE_BYTE;
            r_signed       <= 1'b0;
            r_addr         <= '0;
            r_buf0         <= '0;
            r_buf1         <= '0;
            req.resp_valid <= 1'b0;
            req.resp_data  <= '0;
            req.resp_err   <= 1'b0;
            mem.mem_addr   <= '0;
            mem.mem_wdata  <= '0;
            mem.mem_size   <= SIZE_BYTE;
            mem.mem_we     <= 1'b0;
            mem.mem_re     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req.req_valid) begin
                        r_size   <= req.req_size;
                        r_signed <= req.req_signed;
                        r_addr   <= req.req_addr;
                        if (w_err) begin
                            r_state        <= RESP;
                            req.resp_valid <= 1'b1;
                            req.resp_err   <= 1'b1;
                            req.resp_data  <= '0;
                        end else if (req.req_we) begin
                            r_state       <= WR;
                            mem.mem_we    <= 1'b1;
                            mem.mem_addr  <= req.req_addr;
                            mem.mem_size  <= req.req_size;
                            mem.mem_wdata <= req.req_wdata;
                        end else begin
                            r_state      <= RD0;
                            mem.mem_re   <= 1'b1;
                            mem.mem_addr <= {req.req_addr[31:2], 2'b00};
                            mem.mem_size <= SIZE_WORD;
                        end
                    end
                end
                RD0: begin
                    r_buf0 <= mem.mem_rdata;
                    if (r_crossing) begin
                        r_state      <= RD1;
                        mem.mem_addr <= {r_addr[31:2], 2'b00} + 32'd4;
                    end else begin
                        r_state        <= RESP;
                        mem.mem_re     <= 1'b0;
                        req.resp_valid <= 1'b1;
                        req.resp_err   <= 1'b0;
                        req.resp_data  <= w_load_result;
                    end
                end
                RD1: begin
                    r_buf1         <= mem.mem_rdata;
                    r_state        <= RESP;
                    mem.mem_re     <= 1'b0;
                    req.resp_valid <= 1'b1;
                    req.resp_err   <= 1'b0;
                    req.resp_data  <= w_load_result;
                end
                WR: begin
                    r_state        <= RESP;
                    mem.mem_we     <= 1'b0;
                    req.resp_valid <= 1'b1;
                    req.resp_err   <= 1'b0;
                    req.resp_data  <= '0;
                end
                RESP: begin
                    r_state        <= IDLE;
                    req.resp_valid <= 1'b0;
                    req.resp_err   <= 1'b0;
                    req.resp_data  <= '0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
// Module   : tb_mem_access_unit
// Purpose  : Directed vector bench for mem_access_unit with a small word memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_unit;
    import mem_access_pkg::*;

    logic clock;
    logic reset;

    mem_req_if  rq ();
    mem_port_if mp ();

    mem_access_unit #(.MEM_ADDR(16'h1000)) dut (
        .clock (clock),
        .reset (reset),
        .req   (rq),
        .mem   (mp)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // 16-word memory; the window offset is dropped, lanes follow mem_size.
    logic [31:0] mem [16];

    assign mp.mem_rdata = mem[mp.mem_addr[5:2]];

    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
            mem[0] <= 32'h44332211;
            mem[1] <= 32'h88776655;
        end else if (mp.mem_we) begin
            case (mp.mem_size)
                2'd0:    mem[mp.mem_addr[5:2]][{mp.mem_addr[1:0], 3'b000} +: 8]  <= mp.mem_wdata[7:0];
                2'd1:    mem[mp.mem_addr[5:2]][{mp.mem_addr[1], 4'b0000} +: 16] <= mp.mem_wdata[15:0];
                default: mem[mp.mem_addr[5:2]] <= mp.mem_wdata;
            endcase
        end
    end

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    typedef struct {
        string       name;
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] data;
        logic        err;
        int          lat;
        int          re_n;
        int          we_n;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [1:0]  ms;
    } vec_t;

    task automatic run_vec(input vec_t v);
        int          waited = 0;
        int          lat = 0;
        int          re_n = 0;
        int          we_n = 0;
        int          nacc = 0;
        logic [31:0] data = 32'h0;
        logic [31:0] a0 = 32'h0;
        logic [31:0] a1 = 32'h0;
        logic        err = 1'b0;
        logic [1:0]  ms = 2'd0;
        while (!rq.req_ready && waited < 20) begin
            @(negedge clock);
            waited++;
        end
        check({v.name, "/ready"}, {31'h0, rq.req_ready}, 32'h1);
        rq.req_valid  = 1'b1;
        rq.req_we     = v.we;
        rq.req_size   = v.size;
        rq.req_signed = v.sgn;
        rq.req_addr   = v.addr;
        rq.req_wdata  = v.wdata;
        @(negedge clock);
        rq.req_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (mp.mem_re || mp.mem_we) begin
                if (nacc == 0) begin
                    a0 = mp.mem_addr;
                    ms = mp.mem_size;
                end else if (nacc == 1) begin
                    a1 = mp.mem_addr;
                end
                nacc++;
            end
            if (mp.mem_re) re_n++;
            if (mp.mem_we) we_n++;
            if (rq.resp_valid) begin
                lat  = c;
                data = rq.resp_data;
                err  = rq.resp_err;
                break;
            end
            @(negedge clock);
        end
        check({v.name, "/latency"}, lat, v.lat);
        check({v.name, "/data"},    data, v.data);
        check({v.name, "/err"},     {31'h0, err}, {31'h0, v.err});
        check({v.name, "/re_cycles"}, re_n, v.re_n);
        check({v.name, "/we_cycles"}, we_n, v.we_n);
        check({v.name, "/addr0"},   a0, v.a0);
        check({v.name, "/addr1"},   a1, v.a1);
        check({v.name, "/msize"},   {30'h0, ms}, {30'h0, v.ms});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    vec_t vecs [13];

    initial begin
        logic seen;

        vecs[0]  = '{"lw_aligned",   1'b0, SIZE_WORD, 1'b0, 32'h10000000, 32'h0,        32'h44332211, 1'b0, 2, 1, 0, 32'h10000000, 32'h0,        2'd3};
        vecs[1]  = '{"lb_signed",    1'b0, SIZE_BYTE, 1'b1, 32'h10000007, 32'h0,        32'hFFFFFF88, 1'b0, 2, 1, 0, 32'h10000004, 32'h0,        2'd3};
        vecs[2]  = '{"lbu",          1'b0, SIZE_BYTE, 1'b0, 32'h10000007, 32'h0,        32'h00000088, 1'b0, 2, 1, 0, 32'h10000004, 32'h0,        2'd3};
        vecs[3]  = '{"lh_signed",    1'b0, SIZE_HALF, 1'b1, 32'h10000006, 32'h0,        32'hFFFF8877, 1'b0, 2, 1, 0, 32'h10000004, 32'h0,        2'd3};
        vecs[4]  = '{"lhu",          1'b0, SIZE_HALF, 1'b0, 32'h10000006, 32'h0,        32'h00008877, 1'b0, 2, 1, 0, 32'h10000004, 32'h0,        2'd3};
        vecs[5]  = '{"lw_cross",     1'b0, SIZE_WORD, 1'b0, 32'h10000001, 32'h0,        32'h55443322, 1'b0, 3, 2, 0, 32'h10000000, 32'h10000004, 2'd3};
        vecs[6]  = '{"lh_cross",     1'b0, SIZE_HALF, 1'b1, 32'h10000003, 32'h0,        32'h00005544, 1'b0, 3, 2, 0, 32'h10000000, 32'h10000004, 2'd3};
        vecs[7]  = '{"sb",           1'b1, SIZE_BYTE, 1'b0, 32'h10000002, 32'h000000AB, 32'h0,        1'b0, 2, 0, 1, 32'h10000002, 32'h0,        2'd0};
        vecs[8]  = '{"lw_after_sb",  1'b0, SIZE_WORD, 1'b0, 32'h10000000, 32'h0,        32'h44AB2211, 1'b0, 2, 1, 0, 32'h10000000, 32'h0,        2'd3};
        vecs[9]  = '{"sw_misalign",  1'b1, SIZE_WORD, 1'b0, 32'h10000002, 32'hDEADBEEF, 32'h0,        1'b1, 1, 0, 0, 32'h0,        32'h0,        2'd0};
        vecs[10] = '{"lw_window",    1'b0, SIZE_WORD, 1'b0, 32'h20000000, 32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0,        32'h0,        2'd0};
        vecs[11] = '{"lw_2nd_out",   1'b0, SIZE_WORD, 1'b0, 32'h1000FFFD, 32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0,        32'h0,        2'd0};
        vecs[12] = '{"size_rsvd",    1'b0, SIZE_RSVD, 1'b0, 32'h10000000, 32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0,        32'h0,        2'd0};

        rq.req_valid  = 1'b0;
        rq.req_we     = 1'b0;
        rq.req_size   = 2'd0;
        rq.req_signed = 1'b0;
        rq.req_addr   = 32'h0;
        rq.req_wdata  = 32'h0;
        reset = 1'b1;
        repeat (3) @(negedge clock);

        check("rst_ready",     {31'h0, rq.req_ready}, 32'h1);
        check("rst_resp",      {30'h0, rq.resp_valid, rq.resp_err}, 32'h0);
        check("rst_resp_data", rq.resp_data, 32'h0);
        check("rst_mem_ctl",   {28'h0, mp.mem_we, mp.mem_re, mp.mem_size}, 32'h0);
        check("rst_mem_addr",  mp.mem_addr, 32'h0);
        check("rst_mem_wdata", mp.mem_wdata, 32'h0);
        reset = 1'b0;
        @(negedge clock);

        for (int i = 0; i < 13; i++) run_vec(vecs[i]);

        // Abort a crossing load while its second word is being read.
        for (int w = 0; w < 20 && !rq.req_ready; w++) @(negedge clock);
        rq.req_valid  = 1'b1;
        rq.req_we     = 1'b0;
        rq.req_size   = SIZE_WORD;
        rq.req_signed = 1'b0;
        rq.req_addr   = 32'h10000001;
        @(negedge clock);
        rq.req_valid = 1'b0;
        check("abort_rd0_re", {31'h0, mp.mem_re}, 32'h1);
        @(negedge clock);
        check("abort_rd1_addr", mp.mem_addr, 32'h10000004);
        reset = 1'b1;
        @(negedge clock);
        check("abort_ready",  {31'h0, rq.req_ready}, 32'h1);
        check("abort_mem_re", {31'h0, mp.mem_re}, 32'h0);
        check("abort_resp",   {31'h0, rq.resp_valid}, 32'h0);
        reset = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clock);
            if (rq.resp_valid) seen = 1'b1;
        end
        check("abort_no_resp", {31'h0, seen}, 32'h0);
        run_vec('{"lw_after_abort", 1'b0, SIZE_WORD, 1'b0, 32'h10000004, 32'h0, 32'h88776655, 1'b0, 2, 1, 0, 32'h10000004, 32'h0, 2'd3});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
